// File: rtl/truth_table_sequencer.sv
// Purpose: steps a combinational function through every input vector, captures its truth table and checks it against a golden mask.
// Latency: vector k is sampled (k+1)*(SETTLE+2) cycles after start; done pulses one cycle after the last sample.
// Backpressure: none; start is taken only in IDLE and ignored (not queued) while a run is in progress.
// Optional feature: define TTSEQ_STOP_ON_MISMATCH_EN to end the run at the first mismatching vector.
module truth_table_sequencer #(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [(1<<N)-1:0]   expected,
    input  logic                s_in,
    output logic [N-1:0]        x_out,
    output logic                busy,
    output logic                done,
    output logic [(1<<N)-1:0]   table_out,
    output logic                match,
    output logic [N:0]          mismatch_count,
    output logic                fail,
    output logic [N-1:0]        fail_index
);

    localparam logic [3:0]   SETTLE_L = 4'(SETTLE);
    localparam logic [N-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [3:0]           wait_cnt;
    logic [(1<<N)-1:0]    exp_q;
    logic                 result_vld;
    logic                 vec_mismatch;
    logic                 stop_now;

    // The golden bit for the vector currently on x_out; only meaningful in SAMPLE.
    assign vec_mismatch = (s_in != exp_q[x_out]);

`ifdef TTSEQ_STOP_ON_MISMATCH_EN
    assign stop_now = vec_mismatch;
`else
    assign stop_now = 1'b0;
`endif

    // Next-state and status decode; busy/done are pure functions of the state.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                busy = 1'b1;
                if (wait_cnt == 4'd0) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                busy = 1'b1;
                if (stop_now || (x_out == LAST_VEC)) state_d = ST_DONE;
                else                                 state_d = ST_DRIVE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Vector stepping, settle counter and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_out          <= '0;
            wait_cnt       <= '0;
            exp_q          <= '0;
            table_out      <= '0;
            mismatch_count <= '0;
            fail           <= 1'b0;
            fail_index     <= '0;
            result_vld     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_out          <= '0;
                        wait_cnt       <= SETTLE_L;
                        exp_q          <= expected;
                        table_out      <= '0;
                        mismatch_count <= '0;
                        fail           <= 1'b0;
                        fail_index     <= '0;
                        result_vld     <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                end
                ST_SAMPLE: begin
                    table_out[x_out] <= s_in;
                    if (vec_mismatch) begin
                        // Cannot overflow: at most 2^N vectors are sampled per run.
                        mismatch_count <= mismatch_count + (N+1)'(1);
                        if (!fail) begin
                            fail       <= 1'b1;
                            fail_index <= x_out;
                        end
                    end
                    if (state_d == ST_DRIVE) begin
                        x_out    <= x_out + N'(1);
                        wait_cnt <= SETTLE_L;
                    end else begin
                        // x_out holds the last vector once the run ends.
                        result_vld <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // match is only asserted once a run has completed, so it reads 0 out of reset.
    assign match = result_vld && (table_out == exp_q);

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Sequencing controller for a combinational function under test, such as a three-input function `s = f(x, y, z)`. On `start` it drives every input vector 0 … 2^N−1 in order. It waits a programmable settle time per vector, samples the function output into a captured truth-table mask, and compares the mask against a latched expected mask. It is the hardware replacement for the hand-written per-vector stimulus blocks in the Guia exercises, and sits between a function instance and a self-check or display stage.

## Interface
Parameters:
- `N`, default 3: number of function inputs. Legal range 1..6.
- `SETTLE`, default 1: extra hold cycles per vector before sampling. Legal range 0..15.

Ports:
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: one clock; reset is synchronous and active-high.
- `start` input, 1 bit: run request. Accepted only in IDLE.
- `expected` input, 2^N bits: golden mask. Bit k is the required `s` for input vector k. Latched on the accepting edge.
- `s_in` input, 1 bit: output of the function under test.
- `x_out` output, N bits: input vector to the function. MSB maps to the first input (x), LSB to the last (z).
- `busy` output, 1 bit: run in progress.
- `done` output, 1 bit: one-cycle pulse at end of run.
- `table_out` output, 2^N bits: captured mask. Bit k is the `s_in` sampled for vector k.
- `match` output, 1 bit: `table_out == expected_latched`. Valid from `done` until the next accepted `start`.
- `mismatch_count` output, N+1 bits: number of mismatching vectors.
- `fail` output, 1 bit: at least one mismatch seen in this run.
- `fail_index` output, N bits: index of the first mismatching vector. 0 when `fail` = 0.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- **IDLE**
  - `busy` = 0.
  - `start` = 1 at an edge moves to DRIVE.
  - On that edge: `x_out` ← 0, wait counter ← SETTLE, `table_out` ← 0, `mismatch_count` ← 0, `fail` ← 0, `fail_index` ← 0, `expected` latched.
- **DRIVE**
  - `busy` = 1.
  - Counter decrements once per cycle. When it is 0, the next edge moves to SAMPLE.
  - With SETTLE = 0, DRIVE lasts exactly one cycle.
- **SAMPLE**
  - On the edge leaving SAMPLE: `table_out[x_out]` ← `s_in`.
  - If `s_in` ≠ `expected_latched[x_out]`: `mismatch_count` increments. If `fail` was 0, `fail` ← 1 and `fail_index` ← `x_out`.
  - If `x_out` = 2^N−1, go to DONE.
  - Otherwise `x_out` increments, counter reloads to SETTLE, and the state returns to DRIVE.
- **DONE**
  - `done` = 1 and `busy` = 0 for one cycle, then IDLE.
  - `x_out` holds the last vector.
  - Result outputs hold until the next accepted `start`.
- `start` is ignored in DRIVE, SAMPLE and DONE. No queuing.
- `s_in` and `expected` are never read outside SAMPLE and the accepting edge respectively.

## Timing
- Reset value of all outputs: 0. State after reset is IDLE.
- Reset asserted mid-run aborts the run immediately, with no `done` pulse.
- `x_out` changes only on edges. Each vector is held for SETTLE+1 DRIVE cycles plus 1 SAMPLE cycle.
- `s_in` must be stable by the edge ending SAMPLE. The combinational path from `x_out` to `s_in` has SETTLE+2 cycles.
- Start accepted at edge E0 gives the following:
  - `busy` rises after E0.
  - Vector k is sampled at edge E0 + (k+1)(SETTLE+2).
  - `done` is high during the cycle after edge E0 + 2^N(SETTLE+2).
- Wrap-around: `x_out` never wraps. The run terminates at 2^N−1.
- `mismatch_count` saturates naturally at 2^N, which fits in N+1 bits.

## Configuration
- Macro: `TTSEQ_STOP_ON_MISMATCH_EN`.
- **Defined:** the first mismatch moves SAMPLE straight to DONE after recording it.
  - `mismatch_count` = 1, `fail` = 1, `fail_index` = that vector.
  - `table_out` bits above `fail_index` remain 0.
  - `match` = 0.
- **Undefined:** every vector is always sampled. `fail_index` still reports the first mismatch.

## Test plan
- **Default run, correct function.** N=3, SETTLE=1, DUT `s = ~(x&~y)&~z`, `expected` = 8'h45, `start` pulsed at E0.
  - `x_out` steps 0..7, each held 3 cycles.
  - `done` is high during the cycle after edge E0+24.
  - `table_out` = 8'h45, `match` = 1, `mismatch_count` = 0, `fail` = 0.
- **Wrong expectation.** Same stimulus with `expected` = 8'h44.
  - Without the macro: `table_out` = 8'h45, `match` = 0, `mismatch_count` = 1, `fail_index` = 0.
  - With the macro: `done` after vector 0, i.e. during the cycle after edge E0+3. `table_out` = 8'h01.
- **Fully inverted expectation.** `expected` = 8'hBA.
  - `mismatch_count` = 8, `fail_index` = 0 (macro undefined).
- **Minimum settle.** SETTLE=0.
  - Each vector is held 2 cycles.
  - `done` is high during the cycle after edge E0+16.
  - Same results as the correct-function run.
- **Start ignored while busy.** Assert `start` again during the run.
  - Run length and results are unchanged. No second run begins.
- **Reset mid-run.** Assert `reset` while `x_out` = 3.
  - Next cycle all outputs are 0 and the state is IDLE. No `done` pulse.
  - A subsequent `start` completes normally.
